rr_router_buffered: RTL
=======================

Name: rr_router_buffered

Overview:
- Parametrised, clocked successor to the combinational two-channel router: NUM_IN input channels, each with a FIFO, routed to NUM_OUT output channels.
- Each flit carries a destination field that selects one output.
- Each output has a round-robin arbiter and a registered output stage with a valid/ready handshake.
- Sits between channel sources and sinks in the routing fabric; invalid destinations are dropped and counted.

Parameters:
NUM_IN, 2, number of input channels (2..8)
NUM_OUT, 3, number of output channels (2..8)
DATA_W, 30, flit width in bits
DEST_LSB, 0, bit position of destination field LSB within flit
DEST_W, 2, destination field width; DEST_W >= clog2(NUM_OUT)
FIFO_DEPTH, 4, entries per input FIFO (power of 2, >= 2)
SRC_W, 1, source-index width; equals max(1, clog2(NUM_IN))

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  NUM_IN  per-input flit valid
in_ready  out  NUM_IN  per-input ready; high when that FIFO is not full
in_data  in  NUM_IN*DATA_W  input flits; channel i occupies bits [i*DATA_W +: DATA_W]
out_valid  out  NUM_OUT  per-output flit valid
out_ready  in  NUM_OUT  per-output sink ready
out_data  out  NUM_OUT*DATA_W  output flits, packed like in_data
out_src  out  NUM_OUT*SRC_W  index of the input that supplied each out_data
drop_count  out  16  saturating count of flits dropped for an invalid destination

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - all FIFOs empty; in_ready all 1 once rst deasserts (in_ready = 0 while rst is high);
  - out_valid = 0, out_data = 0, out_src = 0, drop_count = 0;
  - every round-robin pointer = 0.
- Asserting rst mid-operation discards all buffered and in-flight flits immediately.
- Input side:
  - A flit is accepted on input i when in_valid[i] & in_ready[i] at a rising edge.
  - in_ready[i] = !full[i] and is combinational from FIFO state only, never from in_valid.
  - A FIFO that is full with a simultaneous pop on the same edge still shows in_ready = 0 (no pass-through).
- Head decode: the destination of FIFO i's head is d = head[DEST_LSB +: DEST_W].
  - If d >= NUM_OUT, the head is popped on the next edge without arbitration.
  - drop_count increments by 1 per drop and saturates at 16'hFFFF.
  - If several inputs drop on the same edge, the count increments by the number of drops, still saturating.
- Output stage o is loadable when !out_valid[o] | out_ready[o].
- Arbitration for output o:
  - Requesters are the non-empty FIFOs whose valid head destination equals o.
  - When loadable, the first requester at or after rr_ptr[o] (cyclic order) wins.
  - On that edge: the head is popped, out_data[o] and out_src[o] are loaded, out_valid[o] is set to 1, and rr_ptr[o] = winner+1 mod NUM_IN.
  - With no requester: if out_ready[o] was high, out_valid[o] clears; rr_ptr[o] is unchanged.
- Each FIFO pops at most one head per cycle. A head only ever targets one output, so no conflicts arise across outputs.
- Latency: a flit accepted at edge t into an empty FIFO, with the output idle, appears with out_valid high after edge t+1. Full throughput is one flit per output per cycle.
- Holding: while out_valid[o] & !out_ready[o], out_data[o] and out_src[o] hold stable.
- Ordering: flits from the same input to the same output leave in arrival order. There is no ordering guarantee across different inputs.
- Fairness: with k persistent requesters on one output, each is served once every k grants.
- Pointers and counters wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.

Test Plan:
- Reset then single flit: in_data[0] = 30'h0000_0001 (dest 1), in_valid[0] = 1 for one cycle, out_ready = all 1 -> out_valid[1] = 1 exactly one cycle after acceptance, out_data = 30'h1, out_src = 0; other outputs stay 0.
- Contention: inputs 0 and 1 each send 4 flits to dest 2 back-to-back, out_ready[2] = 1 -> grants alternate src 0,1,0,1,...; 8 flits out in 8 consecutive cycles; per-source order preserved.
- Backpressure/full: out_ready[0] = 0 while input 0 sends 6 flits to dest 0 -> in_ready[0] drops after 5 accepted (4 in FIFO + 1 in output register); out_data is stable; releasing out_ready yields all 5 in order.
- Invalid dest: send dest 3 on both inputs on the same cycle -> no out_valid, drop_count goes 0 to 2; preload 16'hFFFE and repeat -> saturates at 16'hFFFF.
- Async reset mid-traffic: pulse rst between clock edges with 3 flits buffered -> out_valid = 0 and in_ready = 0 immediately while rst is high, in_ready = all 1 after deassertion, no stale flit emitted afterwards.
- Parameter sweep: NUM_IN = 4, NUM_OUT = 4, DEST_W = 2, random traffic with random out_ready -> scoreboard shows no loss, no duplication, per-source/per-dest order kept, and max wait <= 3 grants per requester.

Source files
------------

// File: rtl/rr_router_buffered_if.sv
// Flit handshake bundle between channel sources, the router and channel sinks.
// Input side: per-channel valid/ready/data; output side adds the source index.
// master drives flits in and accepts flits out; slave is the router itself.
interface rr_router_buffered_if #(
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 3,
  parameter int DATA_W  = 30,
  parameter int SRC_W   = 1
);
  logic [NUM_IN-1:0]          in_valid;
  logic [NUM_IN-1:0]          in_ready;
  logic [NUM_IN*DATA_W-1:0]   in_data;
  logic [NUM_OUT-1:0]         out_valid;
  logic [NUM_OUT-1:0]         out_ready;
  logic [NUM_OUT*DATA_W-1:0]  out_data;
  logic [NUM_OUT*SRC_W-1:0]   out_src;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_router_buffered.sv
// Buffered NUM_IN x NUM_OUT flit router with per-output round-robin arbitration.
// Latency: flit accepted at edge t into an idle path is valid at the output after edge t+1.
// Backpressure: in_ready follows FIFO fullness only; output registers hold while !out_ready.

// Generic circular FIFO with an extra pointer bit to tell full from empty.
// Latency: pushed word is visible at head after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no pass-through.
module rr_router_buffered_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// Buffered NUM_IN x NUM_OUT router: input FIFOs, head decode, per-output round-robin.
// Latency: one cycle from FIFO head to registered output (two edges from acceptance).
// Backpressure: output stage reloads only when empty or being drained; FIFOs absorb the rest.
module rr_router_buffered #(
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 3,
  parameter int DATA_W     = 30,
  parameter int DEST_LSB   = 0,
  parameter int DEST_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_W      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_router_buffered_if.slave  bus,
  output logic [15:0]          drop_count
);
  logic [NUM_IN-1:0]         fifo_full;
  logic [NUM_IN-1:0]         fifo_empty;
  logic [NUM_IN-1:0]         fifo_pop;
  logic [DATA_W-1:0]         head [NUM_IN];
  logic [DEST_W-1:0]         head_dest [NUM_IN];
  logic [NUM_IN-1:0]         drop;
  logic [16:0]               drop_sum;

  logic [NUM_OUT-1:0]        grant;
  logic [SRC_W-1:0]          winner [NUM_OUT];
  logic [SRC_W-1:0]          rr_ptr [NUM_OUT];
  logic [SRC_W-1:0]          rr_ptr_nxt [NUM_OUT];

  logic [NUM_OUT-1:0]        valid_reg;
  logic [NUM_OUT*DATA_W-1:0] data_reg;
  logic [NUM_OUT*SRC_W-1:0]  src_reg;

  // Readiness depends on FIFO occupancy only, and is forced low during reset.
  assign bus.in_ready  = ~fifo_full & {NUM_IN{~rst}};
  assign bus.out_valid = valid_reg;
  assign bus.out_data  = data_reg;
  assign bus.out_src   = src_reg;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    rr_router_buffered_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.in_valid[i]),
      .pop       (fifo_pop[i]),
      .push_data (bus.in_data[i*DATA_W +: DATA_W]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .head      (head[i])
    );
  end

  // Head decode: heads addressed beyond the last output are dropped without arbitration.
  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < NUM_IN; i++) begin
      head_dest[i] = head[i][DEST_LSB +: DEST_W];
      drop[i]      = ~fifo_empty[i] & (int'(head_dest[i]) >= NUM_OUT);
      drop_sum     = drop_sum + 17'(drop[i]);
    end
  end

  // Per-output round-robin: scanning from the far end back to rr_ptr lets the nearest requester win.
  always_comb begin
    int               sum;
    logic [SRC_W-1:0] idx;
    sum      = 0;
    idx      = '0;
    grant    = '0;
    fifo_pop = drop;
    for (int o = 0; o < NUM_OUT; o++) begin
      winner[o]     = '0;
      rr_ptr_nxt[o] = rr_ptr[o];
      if (~valid_reg[o] | bus.out_ready[o]) begin
        for (int k = NUM_IN - 1; k >= 0; k--) begin
          sum = int'(rr_ptr[o]) + k;
          if (sum >= NUM_IN) sum = sum - NUM_IN;
          idx = SRC_W'(sum);
          if (~fifo_empty[idx] && (int'(head_dest[idx]) == o)) begin
            winner[o] = idx;
            grant[o]  = 1'b1;
          end
        end
      end
      if (grant[o]) begin
        fifo_pop[winner[o]] = 1'b1;
        sum = int'(winner[o]) + 1;
        if (sum >= NUM_IN) sum = 0;
        rr_ptr_nxt[o] = SRC_W'(sum);
      end
    end
  end

  // Output stages and arbiter pointers: load on grant, clear once drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      data_reg  <= '0;
      src_reg   <= '0;
      for (int o = 0; o < NUM_OUT; o++) rr_ptr[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (grant[o]) begin
          valid_reg[o]                   <= 1'b1;
          data_reg[o*DATA_W +: DATA_W]   <= head[winner[o]];
          src_reg[o*SRC_W +: SRC_W]      <= winner[o];
          rr_ptr[o]                      <= rr_ptr_nxt[o];
        end else if (bus.out_ready[o]) begin
          valid_reg[o] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter; several inputs may drop on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                   drop_count <= drop_sum[15:0];
  end
endmodule
